cla_addsub_pipe: RTL and testbench
==================================

// Module: cla_addsub_pipe
// PURPOSE
//  Parametrised, pipelined carry-lookahead add/sub unit for the EX stage; successor to the fixed 4-bit CLA.
//  Supports ADD, SUB and PADDSB (per-lane signed-saturating add), with optional full-width signed saturation.
//  Produces N/Z/V flags and carry-out, and uses valid/ready handshakes on both sides with full backpressure.
// PARAMETERS
//  WIDTH   16  operand/result width; must be a multiple of GROUP and of LANE
//  GROUP   4   bits per lookahead group (one cla_group instance per group)
//  LANE    4   PADDSB sub-word lane width
//  STAGES  2   pipeline depth, legal values 1 or 2; also the latency in cycles
// PORTS
//  clk        in   1      clock, rising edge
//  rst_n      in   1      asynchronous active-low reset
//  in_valid   in   1      operand beat valid
//  in_ready   out  1      unit can accept a beat this cycle
//  op         in   2      operation: 00 ADD, 01 SUB, 10 PADDSB, 11 reserved (treated as ADD)
//  sat_en     in   1      saturate ADD/SUB on signed overflow
//  a          in   WIDTH  operand A
//  b          in   WIDTH  operand B
//  out_valid  out  1      result beat valid
//  out_ready  in   1      consumer accepts the result this cycle
//  result     out  WIDTH  sum or difference
//  cout       out  1      carry-out of the MSB; for SUB = NOT borrow; 0 for PADDSB
//  flag_n     out  1      result[WIDTH-1]
//  flag_z     out  1      result == 0
//  flag_v     out  1      signed overflow before saturation; PADDSB: OR of lane overflows
// BEHAVIOUR
//  Reset: every stage valid bit clears and result/cout/flags are forced to 0 asynchronously on rst_n low. in_ready=1 after release.
//  Handshake: a beat transfers when valid && ready. Each stage register loads when it is empty or its contents move on this cycle.
//   in_ready = !stage0_valid || stage0_advances; this gives back-to-back issue at 1 beat per cycle under out_ready=1.
//  Outputs are held stable while out_valid && !out_ready. No beat is lost, duplicated or reordered.
//  Latency: exactly STAGES cycles from input acceptance to out_valid, with no stalls.
//  Arithmetic: SUB computes a + ~b + 1 (cin=1). ADD uses cin=0. All arithmetic is two's complement, WIDTH bits.
//   Group P/G are computed per GROUP bits. Group carries are formed by a second-level lookahead.
//   STAGES=2 registers: group P/G, carry-in, op, sat_en and operands after level 1; carries, sums and flags in stage 2.
//  V = (a_msb == b'_msb) && (sum_msb != a_msb), where b' is the post-invert operand.
//  Saturation (ADD/SUB, sat_en=1, V=1): result = sum_msb ? 0x7F..F : 0x80..0. flag_n and flag_z are computed on the saturated result.
//  PADDSB: lane carries are killed at each LANE boundary. Each lane saturates independently to +2^(LANE-1)-1 or -2^(LANE-1).
//   sat_en is ignored for PADDSB. cout=0.
//  Reserved op 11 behaves as ADD. No error is signalled.
//  Reset asserted mid-operation flushes all in-flight beats; nothing is replayed after reset.
//  Simultaneous out-accept and in-accept on a full pipe is legal and keeps throughput at 1 beat per cycle.
// STRUCTURE
//  Shared package alu_pkg holds: op encodings (OP_ADD, OP_SUB, OP_PADDSB) and the saturation constant functions SAT_MAX(w) and SAT_MIN(w).
//  Sub-module cla_group: GROUP-bit adder with inputs a, b, cin and outputs sum, group P, group G.
//   Instantiate WIDTH/GROUP copies. The second-level lookahead and lane-kill logic stay in this module.
//  Elaboration-time check: WIDTH%GROUP==0, WIDTH%LANE==0 and STAGES in {1,2}; otherwise $fatal.
// TESTING (WIDTH=16, GROUP=4, LANE=4, STAGES=2)
//  ADD 0x7FFF+0x0001, sat_en=1 -> after 2 cycles result=0x7FFF, V=1, N=0, Z=0, cout=0.
//  SUB 0x8000-0x0001, sat_en=1 -> result=0x8000, V=1, N=1; with sat_en=0 -> result=0x7FFF, V=1, N=0.
//  ADD 0x0001+0xFFFF, sat_en=0 -> result=0x0000, Z=1, cout=1, V=0.
//  PADDSB 0x7123+0x1F0E -> result=0x7021, V=1 (lane3 overflow), cout=0.
//  Backpressure: issue 4 beats while out_ready=0 for 3 cycles -> in_ready drops after 2 accepted; all 4 results emerge in order, none lost or duplicated.
//  Reset mid-flight: rst_n low with 2 beats in flight -> out_valid=0 and result=0 immediately; after release the first new beat appears 2 cycles after acceptance.

Source files
------------

// File: rtl/alu_pkg.sv
`timescale 1ns/1ps
// Shared ALU definitions: operation encodings and saturation constant helpers.
package alu_pkg;

    // Operation select; the fourth code is reserved and executes as ADD.
    typedef enum logic [1:0] {
        OP_ADD    = 2'b00,
        OP_SUB    = 2'b01,
        OP_PADDSB = 2'b10,
        OP_RSVD   = 2'b11
    } alu_op_e;

    // Largest positive two's-complement value of a w-bit field (0111..1).
    function automatic logic [63:0] SAT_MAX(input int w);
        logic [63:0] m;
        m = 64'h0;
        for (int i = 0; i < 64; i++) begin
            if (i < w - 1) begin
                m[i] = 1'b1;
            end
        end
        return m;
    endfunction

    // Most negative two's-complement value of a w-bit field (1000..0).
    function automatic logic [63:0] SAT_MIN(input int w);
        logic [63:0] m;
        m = 64'h0;
        for (int i = 0; i < 64; i++) begin
            if (i == w - 1) begin
                m[i] = 1'b1;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/cla_group.sv
`timescale 1ns/1ps
// One lookahead group: W-bit adder producing its sum plus group propagate/generate
// for the second-level lookahead in the parent.
module cla_group #(
    parameter int W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         p,
    output logic         g
);
    logic [W-1:0] bit_p;
    logic [W-1:0] bit_g;
    logic [W-1:0] carry;
    logic         g_acc;

    assign bit_p = a ^ b;
    assign bit_g = a & b;

    // Bit carries inside the group, seeded by the group carry-in.
    always_comb begin
        carry    = '0;
        carry[0] = cin;
        for (int i = 0; i < W - 1; i++) begin
            carry[i+1] = bit_g[i] | (bit_p[i] & carry[i]);
        end
    end

    // Group generate: a carry leaves the group independent of its carry-in.
    always_comb begin
        g_acc = 1'b0;
        for (int i = 0; i < W; i++) begin
            g_acc = bit_g[i] | (bit_p[i] & g_acc);
        end
    end

    assign sum = bit_p ^ carry;
    assign p   = &bit_p;
    assign g   = g_acc;

endmodule

// File: rtl/cla_addsub_pipe.sv
`timescale 1ns/1ps
// Pipelined two-level carry-lookahead ADD / SUB / PADDSB unit with N/Z/V/carry flags
// and valid/ready handshakes on both sides.
module cla_addsub_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int GROUP  = 4,
    parameter int LANE   = 4,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic             sat_en,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             flag_n,
    output logic             flag_z,
    output logic             flag_v
);
    localparam int NG = WIDTH / GROUP;
    localparam int NL = WIDTH / LANE;
    localparam logic [WIDTH-1:0] FULL_MAX = WIDTH'(SAT_MAX(WIDTH));
    localparam logic [WIDTH-1:0] FULL_MIN = WIDTH'(SAT_MIN(WIDTH));
    localparam logic [LANE-1:0]  LANE_MAX = LANE'(SAT_MAX(LANE));
    localparam logic [LANE-1:0]  LANE_MIN = LANE'(SAT_MIN(LANE));

    genvar gi;

    // Lane boundaries must coincide with group boundaries so the lane kill can
    // act on group carry-ins.
    generate
        if ((WIDTH % GROUP) != 0 || (WIDTH % LANE) != 0 || (LANE % GROUP) != 0 ||
            !(STAGES == 1 || STAGES == 2)) begin : g_bad_params
            $fatal(1, "cla_addsub_pipe: illegal WIDTH/GROUP/LANE/STAGES combination");
        end
    endgenerate

    // ---------------- level 1: operand conditioning and group P/G ----------------
    alu_op_e          op_e;
    logic             l1_sub;
    logic             l1_padd;
    logic [WIDTH-1:0] l1_bx;
    logic [WIDTH-1:0] l1_sum0;
    logic [NG-1:0]    l1_p;
    logic [NG-1:0]    l1_g;
    logic [NL-1:0]    l1_a_sgn;
    logic [NL-1:0]    l1_b_sgn;

    assign op_e    = alu_op_e'(op);
    assign l1_sub  = (op_e == OP_SUB);
    assign l1_padd = (op_e == OP_PADDSB);
    assign l1_bx   = l1_sub ? ~b : b;

    // Each group adds with carry-in 0; the true carry-in is folded in after the
    // second-level lookahead, so one group adder serves both levels.
    generate
        for (gi = 0; gi < NG; gi++) begin : g_grp
            cla_group #(.W(GROUP)) u_grp (
                .a   (a[gi*GROUP +: GROUP]),
                .b   (l1_bx[gi*GROUP +: GROUP]),
                .cin (1'b0),
                .sum (l1_sum0[gi*GROUP +: GROUP]),
                .p   (l1_p[gi]),
                .g   (l1_g[gi])
            );
        end
        // Only the sign bit of each lane (the top lane's is the full-width sign)
        // is needed downstream for overflow detection.
        for (gi = 0; gi < NL; gi++) begin : g_sgn
            assign l1_a_sgn[gi] = a[(gi+1)*LANE-1];
            assign l1_b_sgn[gi] = l1_bx[(gi+1)*LANE-1];
        end
    endgenerate

    // ---------------- pipeline boundary between level 1 and level 2 ----------------
    logic             out_load;
    logic             l2_valid;
    logic [WIDTH-1:0] l2_sum0;
    logic [NG-1:0]    l2_p;
    logic [NG-1:0]    l2_g;
    logic [NL-1:0]    l2_a_sgn;
    logic [NL-1:0]    l2_b_sgn;
    logic             l2_cin;
    logic             l2_padd;
    logic             l2_sat;

    generate
        if (STAGES == 2) begin : g_two
            logic             s0_valid_q;
            logic [WIDTH-1:0] s0_sum0_q;
            logic [NG-1:0]    s0_p_q;
            logic [NG-1:0]    s0_g_q;
            logic [NL-1:0]    s0_a_sgn_q;
            logic [NL-1:0]    s0_b_sgn_q;
            logic             s0_cin_q;
            logic             s0_padd_q;
            logic             s0_sat_q;

            // Stage 0 frees up whenever it is empty or its beat moves to the output.
            assign in_ready = !s0_valid_q || out_load;

            // Capture level-1 results for an accepted beat.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    s0_valid_q <= 1'b0;
                    s0_sum0_q  <= '0;
                    s0_p_q     <= '0;
                    s0_g_q     <= '0;
                    s0_a_sgn_q <= '0;
                    s0_b_sgn_q <= '0;
                    s0_cin_q   <= 1'b0;
                    s0_padd_q  <= 1'b0;
                    s0_sat_q   <= 1'b0;
                end else if (in_ready) begin
                    s0_valid_q <= in_valid;
                    if (in_valid) begin
                        s0_sum0_q  <= l1_sum0;
                        s0_p_q     <= l1_p;
                        s0_g_q     <= l1_g;
                        s0_a_sgn_q <= l1_a_sgn;
                        s0_b_sgn_q <= l1_b_sgn;
                        s0_cin_q   <= l1_sub;
                        s0_padd_q  <= l1_padd;
                        s0_sat_q   <= sat_en;
                    end
                end
            end

            assign l2_valid = s0_valid_q;
            assign l2_sum0  = s0_sum0_q;
            assign l2_p     = s0_p_q;
            assign l2_g     = s0_g_q;
            assign l2_a_sgn = s0_a_sgn_q;
            assign l2_b_sgn = s0_b_sgn_q;
            assign l2_cin   = s0_cin_q;
            assign l2_padd  = s0_padd_q;
            assign l2_sat   = s0_sat_q;
        end else begin : g_one
            assign in_ready = out_load;
            assign l2_valid = in_valid;
            assign l2_sum0  = l1_sum0;
            assign l2_p     = l1_p;
            assign l2_g     = l1_g;
            assign l2_a_sgn = l1_a_sgn;
            assign l2_b_sgn = l1_b_sgn;
            assign l2_cin   = l1_sub;
            assign l2_padd  = l1_padd;
            assign l2_sat   = sat_en;
        end
    endgenerate

    // ---------------- level 2: group carries, sums, saturation, flags ----------------
    logic [NG:0]      kill;
    logic [NG:0]      gc;
    logic [WIDTH-1:0] l2_sum;
    logic [NL-1:0]    lane_ov;
    logic [WIDTH-1:0] lane_res;
    logic             v_full;

    // For PADDSB the carry into every group that starts a lane is forced to 0.
    generate
        for (gi = 0; gi < NG; gi++) begin : g_kill
            assign kill[gi] = l2_padd && (((gi * GROUP) % LANE) == 0);
        end
    endgenerate
    assign kill[NG] = 1'b0;

    // Second-level lookahead: carry into group k is the OR of every lower group's
    // generate propagated through the groups in between, stopping at a killed boundary.
    always_comb begin
        logic live;
        logic pp;
        logic term;
        gc   = '0;
        live = 1'b0;
        pp   = 1'b0;
        term = 1'b0;
        for (int k = 0; k <= NG; k++) begin
            live = !kill[k];
            pp   = 1'b1;
            term = 1'b0;
            for (int j = NG - 1; j >= 0; j--) begin
                if (j < k) begin
                    term = term | (live & pp & l2_g[j]);
                    pp   = pp & l2_p[j];
                    live = live & !kill[j];
                end
            end
            gc[k] = term | (live & pp & l2_cin);
        end
    end

    // Fold each group carry into the carry-in-0 group sum.
    generate
        for (gi = 0; gi < NG; gi++) begin : g_sum
            assign l2_sum[gi*GROUP +: GROUP] = l2_sum0[gi*GROUP +: GROUP] + GROUP'(gc[gi]);
        end
        // Independent signed saturation per PADDSB lane.
        for (gi = 0; gi < NL; gi++) begin : g_lane
            logic s_sgn;
            assign s_sgn       = l2_sum[(gi+1)*LANE-1];
            assign lane_ov[gi] = (l2_a_sgn[gi] == l2_b_sgn[gi]) && (s_sgn != l2_a_sgn[gi]);
            assign lane_res[gi*LANE +: LANE] = lane_ov[gi] ? (s_sgn ? LANE_MAX : LANE_MIN)
                                                           : l2_sum[gi*LANE +: LANE];
        end
    endgenerate

    assign v_full = (l2_a_sgn[NL-1] == l2_b_sgn[NL-1]) && (l2_sum[WIDTH-1] != l2_a_sgn[NL-1]);

    logic [WIDTH-1:0] result_d;
    logic             cout_d;
    logic             flag_v_d;

    // Select the final result; a negative-looking sum after overflow means the
    // true result was positive, hence saturate high.
    always_comb begin
        result_d = l2_sum;
        cout_d   = gc[NG];
        flag_v_d = v_full;
        if (l2_padd) begin
            result_d = lane_res;
            cout_d   = 1'b0;
            flag_v_d = |lane_ov;
        end else if (l2_sat && v_full) begin
            result_d = l2_sum[WIDTH-1] ? FULL_MAX : FULL_MIN;
        end
    end

    // ---------------- output register ----------------
    logic             out_valid_q;
    logic [WIDTH-1:0] result_q;
    logic             cout_q;
    logic             flag_n_q;
    logic             flag_z_q;
    logic             flag_v_q;

    assign out_load = !out_valid_q || out_ready;

    // Output stage holds its beat while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            result_q    <= '0;
            cout_q      <= 1'b0;
            flag_n_q    <= 1'b0;
            flag_z_q    <= 1'b0;
            flag_v_q    <= 1'b0;
        end else if (out_load) begin
            out_valid_q <= l2_valid;
            if (l2_valid) begin
                result_q <= result_d;
                cout_q   <= cout_d;
                flag_n_q <= result_d[WIDTH-1];
                flag_z_q <= (result_d == '0);
                flag_v_q <= flag_v_d;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign cout      = cout_q;
    assign flag_n    = flag_n_q;
    assign flag_z    = flag_z_q;
    assign flag_v    = flag_v_q;

endmodule

// File: tb/tb_cla_addsub_pipe.sv
`timescale 1ns/1ps
// Self-checking bench for cla_addsub_pipe (WIDTH=16, GROUP=4, LANE=4, STAGES=2).
module tb_cla_addsub_pipe;
    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [1:0]   op = 2'd0;
    logic         sat_en = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] result;
    logic         cout, flag_n, flag_z, flag_v;

    always #5 clk = ~clk;

    cla_addsub_pipe #(.WIDTH(16), .GROUP(4), .LANE(4), .STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .sat_en(sat_en), .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .cout(cout), .flag_n(flag_n), .flag_z(flag_z), .flag_v(flag_v)
    );

    typedef struct {
        logic [15:0] res;
        logic        c, n, z, v;
        int          acc;
        logic [1:0]  op;
        logic [15:0] a, b;
    } exp_t;

    typedef struct packed {
        logic [1:0]  op;
        logic        sat;
        logic [15:0] a, b, res;
        logic        c, n, z, v;
    } dir_t;

    exp_t        sb[$];
    exp_t        e;
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          n_out = 0;
    bit          lat_mode = 1'b0;
    bit          done = 1'b0;
    logic        prev_stall = 1'b0;
    logic [15:0] prev_res = '0;
    logic [15:0] last_res = '0;
    logic        last_c = 1'b0, last_n = 1'b0, last_z = 1'b0, last_v = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: plain signed/unsigned integer arithmetic with clamping.
    function automatic exp_t model(input logic [1:0] o, input logic s,
                                   input logic [15:0] x, input logic [15:0] y);
        exp_t        r;
        int          ex, la, lb, ls;
        logic [16:0] full;
        r.op = o; r.a = x; r.b = y; r.acc = 0;
        r.res = '0; r.c = 1'b0; r.v = 1'b0;
        if (o == 2'd2) begin
            for (int l = 0; l < 4; l++) begin
                la = $signed(x[4*l +: 4]);
                lb = $signed(y[4*l +: 4]);
                ls = la + lb;
                if (ls > 7)       begin ls = 7;  r.v = 1'b1; end
                else if (ls < -8) begin ls = -8; r.v = 1'b1; end
                r.res[4*l +: 4] = 4'(ls);
            end
        end else begin
            if (o == 2'd1) begin
                ex   = int'($signed(x)) - int'($signed(y));
                full = {1'b0, x} + {1'b0, ~y} + 17'd1;
            end else begin
                ex   = int'($signed(x)) + int'($signed(y));
                full = {1'b0, x} + {1'b0, y};
            end
            r.c = full[16];
            r.v = (ex > 32767) || (ex < -32768);
            r.res = (s && r.v) ? ((ex > 0) ? 16'h7FFF : 16'h8000) : full[15:0];
        end
        r.n = r.res[15];
        r.z = (r.res == 16'h0);
        return r;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: scoreboard pops on output transfer, pushes on input transfer.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check_eq("hold_valid", out_valid, 1);
                check_eq("hold_result", result, prev_res);
            end
            prev_stall = out_valid && !out_ready;
            prev_res   = result;
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check_eq("spurious_out", 1, 0);
                end else begin
                    e = sb.pop_front();
                    $display("OUT op=%0d a=%h b=%h res=%h c=%b n=%b z=%b v=%b",
                             e.op, e.a, e.b, result, cout, flag_n, flag_z, flag_v);
                    check_eq("result", result, e.res);
                    check_eq("cout", cout, e.c);
                    check_eq("flag_n", flag_n, e.n);
                    check_eq("flag_z", flag_z, e.z);
                    check_eq("flag_v", flag_v, e.v);
                    if (lat_mode) check_eq("latency", cyc - e.acc, 2);
                end
                n_out++;
                last_res = result; last_c = cout; last_n = flag_n; last_z = flag_z; last_v = flag_v;
            end
            if (in_valid && in_ready) begin
                e = model(op, sat_en, a, b);
                e.acc = cyc;
                sb.push_back(e);
            end
        end
    end

    task automatic send(input logic [1:0] o, input logic s, input logic [15:0] x, input logic [15:0] y);
        int   n;
        logic acc;
        op = o; sat_en = s; a = x; b = y; in_valid = 1'b1;
        n = 0; acc = 1'b0;
        while (!acc && n < 100) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        if (!acc) check_eq("send_timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    task automatic wait_outs(input int target);
        int n;
        n = 0;
        while (n_out < target && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_eq("out_count", n_out, target);
    endtask

    dir_t dirs[8] = '{
        '{2'd0, 1'b1, 16'h7FFF, 16'h0001, 16'h7FFF, 1'b0, 1'b0, 1'b0, 1'b1},
        '{2'd1, 1'b1, 16'h8000, 16'h0001, 16'h8000, 1'b1, 1'b1, 1'b0, 1'b1},
        '{2'd1, 1'b0, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b0, 1'b0, 1'b1},
        '{2'd0, 1'b0, 16'h0001, 16'hFFFF, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0},
        '{2'd2, 1'b0, 16'h7123, 16'h1F0E, 16'h7021, 1'b0, 1'b0, 1'b0, 1'b1},
        '{2'd2, 1'b1, 16'h8888, 16'h8888, 16'h8888, 1'b0, 1'b1, 1'b0, 1'b1},
        '{2'd3, 1'b1, 16'h1234, 16'h1111, 16'h2345, 1'b0, 1'b0, 1'b0, 1'b0},
        '{2'd1, 1'b0, 16'h5A5A, 16'h5A5A, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0}
    };

    logic [15:0] edges[5] = '{16'h0000, 16'h0001, 16'h7FFF, 16'h8000, 16'hFFFF};

    function automatic logic [15:0] pick();
        if ($urandom_range(0, 3) == 0) return edges[$urandom_range(0, 4)];
        return 16'($urandom);
    endfunction

    initial begin
        int base, c0;
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_result", result, 0);
        check_eq("rst_flags", {cout, flag_n, flag_z, flag_v}, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_eq("rst_in_ready", in_ready, 1);

        // Directed vectors, each on an empty pipe
        lat_mode = 1'b1;
        for (int i = 0; i < 8; i++) begin
            base = n_out;
            send(dirs[i].op, dirs[i].sat, dirs[i].a, dirs[i].b);
            wait_outs(base + 1);
            check_eq($sformatf("dir%0d_res", i), last_res, dirs[i].res);
            check_eq($sformatf("dir%0d_flags", i), {last_c, last_n, last_z, last_v},
                     {dirs[i].c, dirs[i].n, dirs[i].z, dirs[i].v});
        end

        // Backpressure: consumer stalls for 3 cycles while 4 beats are offered
        lat_mode = 1'b0;
        base = n_out;
        out_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 4; i++) send(2'd0, 1'b0, 16'(i * 16'h1111), 16'h0101);
            end
            begin
                repeat (2) @(posedge clk);
                #2;
                check_eq("bp_in_ready", in_ready, 0);
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        wait_outs(base + 4);

        // Reset with two beats in flight
        send(2'd0, 1'b0, 16'h1000, 16'h0001);
        send(2'd0, 1'b0, 16'h2000, 16'h0002);
        rst_n = 1'b0;
        #1;
        check_eq("midrst_out_valid", out_valid, 0);
        check_eq("midrst_result", result, 0);
        sb.delete();
        base = n_out;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_eq("flush_no_out", n_out, base);
        lat_mode = 1'b1;
        send(2'd1, 1'b0, 16'h0005, 16'h0007);
        wait_outs(base + 1);
        check_eq("postrst_res", last_res, 16'hFFFE);

        // Back-to-back random beats at full throughput
        base = n_out;
        c0 = cyc;
        for (int i = 0; i < 50; i++) send(2'($urandom_range(0, 3)), 1'($urandom), pick(), pick());
        check_eq("throughput_cycles", cyc - c0, 50);
        wait_outs(base + 50);

        // Random beats with random consumer stalls
        lat_mode = 1'b0;
        base = n_out;
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 250; i++) send(2'($urandom_range(0, 3)), 1'($urandom), pick(), pick());
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
        join
        wait_outs(base + 250);
        check_eq("sb_empty", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
